// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and the FSM
// state type used by alu_pipe.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_NEG = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_SAR = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier.
// Ports:
//   clk, rst  clock and async active-high reset
//   start     load operands and begin WIDTH iterations
//   a, b      multiplicand / multiplier, sampled only on start
//   done      high during the final iteration; product is complete then
//   product   combinational view of the accumulator after this cycle's step
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   // Exposing the post-step sum lets the caller capture the full product
   // in the last iteration instead of one cycle later.
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = (count == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         count  <= CW'(WIDTH);
      end else if (count != '0) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst               clock and async active-high reset
//   in_valid/in_ready      operand handshake (operand1, operand2, opcode)
//   out_valid/out_ready    result handshake (result, flags, illegal_op)
//   carryflag              carry / borrow / shifted-out bit
//   overflowflag           signed overflow (mul: high half non-zero)
//   zeroflag, negativeflag result == 0, result MSB
//   illegal_op             reserved opcode (or mul when MUL_EN = 0)
//
// state | meaning
// IDLE  | ready for a new operation when the output slot is free/draining
// MUL   | multiplier iterating; input stalled
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  operand1,
   input  logic [WIDTH-1:0]  operand2,
   input  logic [3:0]        opcode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              carryflag,
   output logic              overflowflag,
   output logic              zeroflag,
   output logic              negativeflag,
   output logic              illegal_op
);

   localparam int M = WIDTH - 1;

   state_t              state;
   logic                accept;
   logic                is_mul;
   logic                mul_done;
   logic [2*WIDTH-1:0]  product;
   logic [WIDTH:0]      sum;
   logic [WIDTH:0]      diff;
   logic [WIDTH-1:0]    alu_res;
   logic                alu_c;
   logic                alu_v;
   logic                alu_ill;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = MUL_EN && (opcode == OP_MUL);
   assign sum      = {1'b0, operand1} + {1'b0, operand2};
   assign diff     = {1'b0, operand1} - {1'b0, operand2};

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (operand1),
      .b       (operand2),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = sum[M:0];
            alu_c   = sum[WIDTH];
            alu_v   = (operand1[M] == operand2[M]) && (sum[M] != operand1[M]);
         end
         OP_SUB: begin
            alu_res = diff[M:0];
            alu_c   = diff[WIDTH];
            alu_v   = (operand1[M] != operand2[M]) && (diff[M] != operand1[M]);
         end
         OP_AND: alu_res = operand1 & operand2;
         OP_OR:  alu_res = operand1 | operand2;
         OP_XOR: alu_res = operand1 ^ operand2;
         OP_NOT: alu_res = ~operand1;
         OP_NEG: begin
            alu_res = '0 - operand1;
            alu_v   = (operand1 == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_SHL: begin
            alu_res = {operand1[M-1:0], 1'b0};
            alu_c   = operand1[M];
            alu_v   = operand1[M] ^ operand1[M-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, operand1[M:1]};
            alu_c   = operand1[0];
         end
         OP_SAR: begin
            alu_res = {operand1[M], operand1[M:1]};
            alu_c   = operand1[0];
         end
         OP_MUL:  alu_ill = !MUL_EN;
         default: alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         out_valid    <= 1'b0;
         result       <= '0;
         carryflag    <= 1'b0;
         overflowflag <= 1'b0;
         zeroflag     <= 1'b0;
         negativeflag <= 1'b0;
         illegal_op   <= 1'b0;
      end else begin
         // Drain first; a load below in the same cycle overrides it.
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= MUL;
                  end else begin
                     out_valid    <= 1'b1;
                     result       <= alu_res;
                     carryflag    <= alu_c;
                     overflowflag <= alu_v;
                     zeroflag     <= ~|alu_res;
                     negativeflag <= alu_res[M];
                     illegal_op   <= alu_ill;
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  state        <= IDLE;
                  out_valid    <= 1'b1;
                  result       <= product[M:0];
                  carryflag    <= |product[2*WIDTH-1:WIDTH];
                  overflowflag <= |product[2*WIDTH-1:WIDTH];
                  zeroflag     <= ~|product[M:0];
                  negativeflag <= product[M];
                  illegal_op   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
      logic       ill;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [4:0] fl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       v0 = 1'b0;
   logic [7:0] operand1 = '0;
   logic [7:0] operand2 = '0;
   logic [3:0] opcode = '0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, carryflag, overflowflag, zeroflag, negativeflag, illegal_op;
   logic [7:0] result;
   logic       in_ready0, out_valid0, c0, ov0, z0, n0, ill0;
   logic [7:0] result0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand1(operand1), .operand2(operand2), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carryflag(carryflag), .overflowflag(overflowflag), .zeroflag(zeroflag),
      .negativeflag(negativeflag), .illegal_op(illegal_op)
   );

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(in_ready0),
      .operand1(operand1), .operand2(operand2), .opcode(opcode),
      .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
      .carryflag(c0), .overflowflag(ov0), .zeroflag(z0),
      .negativeflag(n0), .illegal_op(ill0)
   );

   // Reference behaviour from the operation rules, plain integer arithmetic.
   function automatic exp_t model(logic [3:0] op, int a, int b, bit mul_en);
      exp_t e;
      int r, sa, sb;
      e = '0;
      r = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      case (op)
         4'd0: begin r = a + b; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
         4'd1: begin r = a - b; e.c = (a < b);   e.v = (sa - sb > 127) || (sa - sb < -128); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = 255 - a;
         4'd5: r = a ^ b;
         4'd6: begin r = 256 - a; e.v = (a == 128); end
         4'd7: begin r = a * 2; e.c = (a >= 128); e.v = (a >= 128) != ((a % 128) >= 64); end
         4'd8: begin r = a / 2; e.c = (a % 2) == 1; end
         4'd9: begin r = a / 2 + ((a >= 128) ? 128 : 0); e.c = (a % 2) == 1; end
         4'd10: begin
            if (mul_en) begin r = a * b; e.c = (r > 255); e.v = (r > 255); end
            else e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      e.res = 8'(r & 255);
      e.z   = (e.res == 8'h00);
      e.n   = e.res[7];
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle model of the handshake: busy counts remaining multiply cycles.
   logic m_ov = 1'b0;
   int   m_busy = 0;
   exp_t m_exp = '0;
   exp_t m_pend = '0;

   always @(posedge clk or posedge rst) begin : mdl
      exp_t e;
      bit   rdy;
      if (rst) begin
         m_ov   <= 1'b0;
         m_busy <= 0;
      end else begin
         rdy = (m_busy == 0) && (!m_ov || out_ready);
         if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_ov  <= 1'b1;
               m_exp <= m_pend;
            end else if (m_ov && out_ready) begin
               m_ov <= 1'b0;
            end
         end else if (in_valid && rdy) begin
            e = model(opcode, int'(operand1), int'(operand2), 1'b1);
            if (opcode == 4'd10) begin
               m_busy <= 8;
               m_pend <= e;
               if (m_ov && out_ready) m_ov <= 1'b0;
            end else begin
               m_ov  <= 1'b1;
               m_exp <= e;
            end
         end else if (m_ov && out_ready) begin
            m_ov <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, (m_busy == 0) && (!m_ov || out_ready)});
      chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
         chk("cyc_result", {24'd0, result}, {24'd0, m_exp.res});
         chk("cyc_flags", {27'd0, carryflag, overflowflag, zeroflag, negativeflag, illegal_op},
             {27'd0, m_exp.c, m_exp.v, m_exp.z, m_exp.n, m_exp.ill});
      end
   end

   task automatic do_op(logic [3:0] op, logic [7:0] a, logic [7:0] b);
      int k;
      in_valid = 1'b1;
      opcode   = op;
      operand1 = a;
      operand2 = b;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 50);
      chk("issue_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      opcode   = 4'($urandom);
   endtask

   function automatic logic [4:0] dflags();
      return {carryflag, overflowflag, zeroflag, negativeflag, illegal_op};
   endfunction

   vec_t vt[15];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nrdy, cnt;
      exp_t pm;

      vt[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b01010};
      vt[1]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b10100};
      vt[2]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 5'b10010};
      vt[3]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b01000};
      vt[4]  = '{4'd6,  8'h80, 8'h00, 8'h80, 5'b01010};
      vt[5]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000};
      vt[6]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 5'b00010};
      vt[7]  = '{4'd5,  8'hAA, 8'hFF, 8'h55, 5'b00000};
      vt[8]  = '{4'd4,  8'h0F, 8'h00, 8'hF0, 5'b00010};
      vt[9]  = '{4'd7,  8'hC0, 8'h00, 8'h80, 5'b10010};
      vt[10] = '{4'd8,  8'h81, 8'h00, 8'h40, 5'b10000};
      vt[11] = '{4'd9,  8'h81, 8'h00, 8'hC0, 5'b10010};
      vt[12] = '{4'd12, 8'h55, 8'h00, 8'h00, 5'b00101};
      vt[13] = '{4'd10, 8'h10, 8'h10, 8'h00, 5'b11100};
      vt[14] = '{4'd10, 8'h0F, 8'h03, 8'h2D, 5'b00000};

      // Pin the reference model against hand-computed values.
      pm = model(4'd9, 8'h81, 8'h00, 1'b1);
      chk("model_sar", {24'd0, pm.res}, 32'hC0);
      pm = model(4'd10, 8'h10, 8'h10, 1'b1);
      chk("model_mul_flags", {27'd0, pm.c, pm.v, pm.z, pm.n, pm.ill}, 32'b11100);
      pm = model(4'd10, 8'h10, 8'h10, 1'b0);
      chk("model_mul_off", {27'd0, pm.c, pm.v, pm.z, pm.n, pm.ill}, 32'b00101);

      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_flags", {27'd0, dflags()}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (vt[i]) begin
         do_op(vt[i].op, vt[i].a, vt[i].b);
         lat = 0;
         nrdy = 0;
         do begin
            @(negedge clk);
            lat++;
            if (!in_ready) nrdy++;
         end while (!out_valid && lat < 20);
         chk($sformatf("vec%0d_latency", i), lat, (vt[i].op == 4'd10) ? 9 : 1);
         chk($sformatf("vec%0d_stall", i), nrdy, (vt[i].op == 4'd10) ? 8 : 0);
         chk($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vt[i].res});
         chk($sformatf("vec%0d_flags", i), {27'd0, dflags()}, {27'd0, vt[i].fl});
      end

      // Backpressure: result held while the consumer stalls.
      @(posedge clk);
      #1 out_ready = 1'b0;
      do_op(4'd0, 8'h01, 8'h01);
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {24'd0, result}, 32'h02);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", {24'd0, result}, 32'h02);
      @(posedge clk);
      #1 out_ready = 1'b1;
      do_op(4'd5, 8'hF0, 8'hFF);
      @(negedge clk);
      chk("bp_new_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_new_result", {24'd0, result}, 32'h0F);

      // Multiplier absent: 1010 behaves as a one-cycle illegal op.
      @(posedge clk);
      #1;
      v0 = 1'b1;
      opcode = 4'd10;
      operand1 = 8'h03;
      operand2 = 8'h04;
      @(negedge clk);
      chk("nomul_ready", {31'd0, in_ready0}, 32'd1);
      @(posedge clk);
      #1 v0 = 1'b0;
      @(negedge clk);
      chk("nomul_valid", {31'd0, out_valid0}, 32'd1);
      chk("nomul_result", {24'd0, result0}, 32'd0);
      chk("nomul_flags", {27'd0, c0, ov0, z0, n0, ill0}, 32'b00101);

      // Reset during a multiply aborts it and clears outputs immediately.
      do_op(4'd0, 8'h11, 8'h22);
      @(negedge clk);
      chk("pre_rst_result", {24'd0, result}, 32'h33);
      do_op(4'd10, 8'h0F, 8'h03);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_result", {24'd0, result}, 32'd0);
      chk("async_rst_flags", {27'd0, dflags()}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("aborted_no_output", cnt, 0);

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
